// File: rtl/victim_cache_assoc_if.sv
// Lookup, insert, write-back and flush signals of the victim buffer, plus FSM debug state.
// The stat_* counters exist only when VICTIM_CACHE_STATS_EN is defined.
interface victim_cache_assoc_if #(
    parameter int TAG_WIDTH  = 28,
    parameter int LINE_WIDTH = 128
);
    logic                  lookup_req_i;
    logic [TAG_WIDTH-1:0]  lookup_line_addr_i;
    logic                  lookup_hit_o;
    logic [LINE_WIDTH-1:0] lookup_data_o;
    logic                  lookup_dirty_o;
    logic                  insert_req_i;
    logic [TAG_WIDTH-1:0]  insert_line_addr_i;
    logic [LINE_WIDTH-1:0] insert_data_i;
    logic                  insert_dirty_i;
    logic                  insert_ready_o;
    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [TAG_WIDTH-1:0]  wb_addr_o;
    logic [LINE_WIDTH-1:0] wb_data_o;
    logic                  flush_i;
    logic                  flush_done_o;
    logic [1:0]            fsm_state;

    // Write-back: a line transfers on any cycle with wb_valid_o && wb_ready_i; while
    // wb_valid_o is high without wb_ready_i, wb_addr_o/wb_data_o stay stable.
`ifdef VICTIM_CACHE_STATS_EN
    logic [15:0] stat_hits_o;
    logic [15:0] stat_misses_o;
    logic [15:0] stat_wbs_o;

    modport slave (
        input  lookup_req_i, lookup_line_addr_i, insert_req_i, insert_line_addr_i,
               insert_data_i, insert_dirty_i, wb_ready_i, flush_i,
        output lookup_hit_o, lookup_data_o, lookup_dirty_o, insert_ready_o, wb_valid_o,
               wb_addr_o, wb_data_o, flush_done_o, fsm_state,
               stat_hits_o, stat_misses_o, stat_wbs_o
    );
    modport master (
        output lookup_req_i, lookup_line_addr_i, insert_req_i, insert_line_addr_i,
               insert_data_i, insert_dirty_i, wb_ready_i, flush_i,
        input  lookup_hit_o, lookup_data_o, lookup_dirty_o, insert_ready_o, wb_valid_o,
               wb_addr_o, wb_data_o, flush_done_o, fsm_state,
               stat_hits_o, stat_misses_o, stat_wbs_o
    );
`else
    modport slave (
        input  lookup_req_i, lookup_line_addr_i, insert_req_i, insert_line_addr_i,
               insert_data_i, insert_dirty_i, wb_ready_i, flush_i,
        output lookup_hit_o, lookup_data_o, lookup_dirty_o, insert_ready_o, wb_valid_o,
               wb_addr_o, wb_data_o, flush_done_o, fsm_state
    );
    modport master (
        output lookup_req_i, lookup_line_addr_i, insert_req_i, insert_line_addr_i,
               insert_data_i, insert_dirty_i, wb_ready_i, flush_i,
        input  lookup_hit_o, lookup_data_o, lookup_dirty_o, insert_ready_o, wb_valid_o,
               wb_addr_o, wb_data_o, flush_done_o, fsm_state
    );
`endif
endinterface

// File: rtl/victim_cache_assoc.sv
// Fully associative victim buffer with swap-out lookups, one-entry write-back register
// and a flush FSM. Define VICTIM_CACHE_STATS_EN to add hit/miss/write-back counters.
module victim_cache_assoc #(
    parameter int NUM_ENTRIES = 4,
    parameter int LINE_WIDTH  = 128,
    parameter int TAG_WIDTH   = 28
) (
    input logic clk,
    input logic rst,
    victim_cache_assoc_if.slave bus
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    state_t state, state_nx;

    logic [NUM_ENTRIES-1:0] valid_q, dirty_q;
    logic [TAG_WIDTH-1:0]   tag_q  [NUM_ENTRIES];
    logic [LINE_WIDTH-1:0]  data_q [NUM_ENTRIES];
    logic [IW-1:0]          rr_ptr, scan_idx;
    logic                   wb_valid_q;
    logic [TAG_WIDTH-1:0]   wb_addr_q;
    logic [LINE_WIDTH-1:0]  wb_data_q;
    logic                   hit_q, hit_dirty_q;
    logic [LINE_WIDTH-1:0]  hit_data_q;

    logic [NUM_ENTRIES-1:0] lk_match, ins_match;
    logic [IW-1:0]          lk_idx, ins_idx, free_idx, ins_slot;
    logic lk_hit, ins_hit, full, ins_fire, insert_ready, wb_hs, wb_free;
    logic scan_dirty, scan_adv, scan_load, evict_load;

    // Descending loops leave the lowest matching/free index selected.
    always_comb begin
        lk_match = '0;
        ins_match = '0;
        lk_idx = '0;
        ins_idx = '0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            lk_match[i]  = valid_q[i] && (tag_q[i] == bus.lookup_line_addr_i);
            ins_match[i] = valid_q[i] && (tag_q[i] == bus.insert_line_addr_i);
            if (lk_match[i])  lk_idx = IW'(i);
            if (ins_match[i]) ins_idx = IW'(i);
            if (!valid_q[i])  free_idx = IW'(i);
        end
    end

    assign full       = &valid_q;
    assign ins_hit    = |ins_match;
    assign ins_slot   = ins_hit ? ins_idx : (!full ? free_idx : rr_ptr);
    assign lk_hit     = bus.lookup_req_i && (state == IDLE) && (|lk_match);
    assign wb_hs      = wb_valid_q && bus.wb_ready_i;
    assign wb_free    = !wb_valid_q || bus.wb_ready_i;
    assign ins_fire   = bus.insert_req_i && insert_ready;
    assign evict_load = ins_fire && !ins_hit && full && dirty_q[rr_ptr];
    assign scan_dirty = valid_q[scan_idx] && dirty_q[scan_idx];
    assign scan_adv   = !scan_dirty || wb_free;
    assign scan_load  = (state == SCAN) && scan_dirty && wb_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.flush_i) state_nx = SCAN;
            SCAN:    if (scan_adv && scan_idx == LAST_IDX) state_nx = DRAIN;
            DRAIN:   if (!wb_valid_q) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Block inserts only when a dirty eviction would collide with a stalled write-back.
    always_comb begin
        insert_ready = (state == IDLE) &&
                       !(full && dirty_q[rr_ptr] && wb_valid_q && !bus.wb_ready_i);
        bus.flush_done_o = (state == DONE);
        bus.fsm_state    = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            rr_ptr      <= '0;
            scan_idx    <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            hit_q       <= 1'b0;
            hit_dirty_q <= 1'b0;
            hit_data_q  <= '0;
        end else begin
            hit_q       <= lk_hit;
            hit_dirty_q <= lk_hit && dirty_q[lk_idx];
            if (lk_hit) begin
                hit_data_q       <= data_q[lk_idx];
                valid_q[lk_idx]  <= 1'b0;
                dirty_q[lk_idx]  <= 1'b0;
            end
            // Insert lands after the lookup invalidation so it wins on the same slot.
            if (ins_fire) begin
                valid_q[ins_slot] <= 1'b1;
                dirty_q[ins_slot] <= bus.insert_dirty_i || (ins_hit && dirty_q[ins_slot]);
                if (!ins_hit && full) rr_ptr <= rr_ptr + 1'b1;
            end
            if (evict_load) begin
                wb_valid_q <= 1'b1;
                wb_addr_q  <= tag_q[rr_ptr];
                wb_data_q  <= data_q[rr_ptr];
            end else if (scan_load) begin
                wb_valid_q <= 1'b1;
                wb_addr_q  <= tag_q[scan_idx];
                wb_data_q  <= data_q[scan_idx];
            end else if (wb_hs) begin
                wb_valid_q <= 1'b0;
            end
            if (state == IDLE && bus.flush_i) scan_idx <= '0;
            if (state == SCAN && scan_adv) begin
                valid_q[scan_idx] <= 1'b0;
                dirty_q[scan_idx] <= 1'b0;
                scan_idx <= scan_idx + 1'b1;
            end
            if (state == DONE) rr_ptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ins_fire) begin
            tag_q[ins_slot]  <= bus.insert_line_addr_i;
            data_q[ins_slot] <= bus.insert_data_i;
        end
    end

    assign bus.lookup_hit_o   = hit_q;
    assign bus.lookup_dirty_o = hit_dirty_q;
    assign bus.lookup_data_o  = hit_data_q;
    assign bus.insert_ready_o = insert_ready;
    assign bus.wb_valid_o     = wb_valid_q;
    assign bus.wb_addr_o      = wb_addr_q;
    assign bus.wb_data_o      = wb_data_q;

`ifdef VICTIM_CACHE_STATS_EN
    logic [15:0] hits_q, misses_q, wbs_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            if (lk_hit && hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
            if (bus.lookup_req_i && !lk_hit && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
            if (wb_hs && wbs_q != 16'hFFFF) wbs_q <= wbs_q + 16'd1;
        end
    end
    assign bus.stat_hits_o   = hits_q;
    assign bus.stat_misses_o = misses_q;
    assign bus.stat_wbs_o    = wbs_q;
`endif
endmodule

// File: doc/victim_cache_assoc.md
Name: victim_cache_assoc

Overview:
- Parametrised, fully associative victim buffer beside the write-back data cache.
- Receives lines the dcache evicts and returns a line on a registered lookup hit (swap-out semantics: a hit removes the line).
- Dirty victims displaced from a full buffer go to memory through a one-entry write-back register with a valid/ready handshake.
- Supports a full flush sequence.

Parameters:
- NUM_ENTRIES, 4, victim entries; power of two, 2..16.
- LINE_WIDTH, 128, cache line bits.
- TAG_WIDTH, 28, line address bits (byte address minus offset bits).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- lookup_req_i  in  1  lookup strobe.
- lookup_line_addr_i  in  TAG_WIDTH  line address to search.
- lookup_hit_o  out  1  registered hit, valid the cycle after lookup_req_i.
- lookup_data_o  out  LINE_WIDTH  hit line data (registered).
- lookup_dirty_o  out  1  hit line dirty flag (registered).
- insert_req_i  in  1  insert strobe; accepted when insert_ready_o=1.
- insert_line_addr_i  in  TAG_WIDTH  victim line address.
- insert_data_i  in  LINE_WIDTH  victim line data.
- insert_dirty_i  in  1  victim dirty flag.
- insert_ready_o  out  1  buffer can accept an insert this cycle.
- wb_valid_o  out  1  write-back register holds a line.
- wb_ready_i  in  1  memory accepts the write-back.
- wb_addr_o  out  TAG_WIDTH  write-back line address.
- wb_data_o  out  LINE_WIDTH  write-back line data.
- flush_i  in  1  start a flush (single-cycle pulse).
- flush_done_o  out  1  one-cycle pulse when the flush completes.

Behaviour:
- Reset (async, rst=1):
  - All entry valid/dirty bits cleared; replacement pointer rr_ptr=0; FSM to IDLE; write-back register emptied.
  - lookup_hit_o, lookup_data_o, lookup_dirty_o, wb_valid_o, wb_addr_o, wb_data_o, flush_done_o all 0.
  - insert_ready_o is 1 once rst deasserts.
  - Reset mid-flush or mid-write-back abandons the operation with no write-back emitted.
- Lookup:
  - Parallel compare against all valid entries; result registered, so latency is 1 cycle.
  - On hit: the entry is invalidated in the same clock edge that registers the result.
  - On miss, or with no lookup_req_i: lookup_hit_o=0, lookup_dirty_o=0, lookup_data_o holds its last value.
- Insert, accepted when insert_req_i && insert_ready_o. Slot selection uses pre-cycle state:
  - Address already resident: overwrite that entry in place; dirty = old dirty OR insert_dirty_i.
  - Else, a free entry exists: write the lowest-index free entry; rr_ptr unchanged.
  - Else (buffer full): replace entry[rr_ptr]; rr_ptr = (rr_ptr+1) mod NUM_ENTRIES, wrapping NUM_ENTRIES-1 -> 0. If the replaced entry is dirty, its address and data load the write-back register; a clean replaced entry is dropped silently.
- insert_ready_o = 0 when any of the following holds; otherwise 1:
  - FSM is not IDLE;
  - the buffer is full, entry[rr_ptr] is dirty, and wb_valid_o=1 && !wb_ready_i.
- Write-back handshake:
  - wb_valid_o stays high with stable address/data until the cycle wb_ready_i=1, then clears.
  - A new load in the same cycle as the handshake is legal; the register refills the next cycle.
- Simultaneous lookup and insert:
  - The lookup sees pre-cycle contents.
  - If the insert targets the entry the lookup hit, the insert wins (entry ends valid with the new line) and lookup_hit_o still reports the old line.
  - A lookup hit frees a slot only for the following cycle.
- Flush FSM:
  - IDLE: flush_i -> SCAN, scan index idx=0. Lookups return miss and inserts are blocked until the FSM returns to IDLE.
  - SCAN: if entry[idx] is valid and dirty: when the write-back register is free or handing off this cycle, load it, invalidate the entry and advance; otherwise stay. Clean or invalid entries: invalidate and advance. After idx = NUM_ENTRIES-1 -> DRAIN.
  - DRAIN: wait until wb_valid_o=0 -> DONE.
  - DONE: flush_done_o=1 for one cycle, rr_ptr=0 -> IDLE.
  - flush_i while not IDLE is ignored. Empty-buffer flush completes in NUM_ENTRIES+2 cycles.

Optional Feature:
- Macro VICTIM_CACHE_STATS_EN.
- Defined: adds outputs stat_hits_o, stat_misses_o, stat_wbs_o, 16 bits each. They count lookup hits, lookup misses, and write-back handshakes. They saturate at 16'hFFFF, clear on rst, and do not clear on flush.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Insert addr 0x0000010 (data A, clean), then lookup 0x0000010 -> next cycle lookup_hit_o=1, data=A, dirty=0; repeat lookup -> hit=0.
- Fill 4 clean entries 0x1..0x4, insert 0x5 -> entry 0 (0x1) replaced, rr_ptr=1, wb_valid_o stays 0; lookup 0x1 misses, lookup 0x5 hits.
- Fill 4 dirty entries, hold wb_ready_i=0, insert 0x5 then 0x6 -> wb_addr_o=0x1 held; insert_ready_o=0 for 0x6 until wb_ready_i=1, then wb_addr_o=0x2.
- Insert 0x7 clean, then 0x7 dirty with new data B -> single entry, lookup returns B, dirty=1.
- 2 dirty + 1 clean resident, flush_i, wb_ready_i=1 -> two write-backs in index order, flush_done_o pulses once, all subsequent lookups miss, insert_ready_o=1 afterwards.
- Assert rst during SCAN with wb_valid_o=1 -> wb_valid_o=0, flush_done_o never pulses, all lookups miss after release.
